// File: rtl/pap_alu.sv
// pap_alu: single-lane execute unit of the dual-issue PAP datapath.
// Registered result/rd/pc; lane 1 leaves the shared pc net floating.
module pap_alu (
   input  logic        clk,
   input  logic        rs,
   input  logic        lane,
   input  logic [31:0] instr,
   input  logic [31:0] pc_in,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [31:0] op_c,
   input  logic        en,
   input  logic        wen,
   output logic [4:0]  rd_out,
   output logic [31:0] pc_out,
   output logic [31:0] result
);

   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_ADD  = 6'h01;
   localparam logic [5:0] OP_SUB  = 6'h02;
   localparam logic [5:0] OP_AND  = 6'h03;
   localparam logic [5:0] OP_OR   = 6'h04;
   localparam logic [5:0] OP_XOR  = 6'h05;
   localparam logic [5:0] OP_NOR  = 6'h06;
   localparam logic [5:0] OP_SLT  = 6'h07;
   localparam logic [5:0] OP_SLTU = 6'h08;
   localparam logic [5:0] OP_SLL  = 6'h09;
   localparam logic [5:0] OP_SRL  = 6'h0A;
   localparam logic [5:0] OP_SRA  = 6'h0B;
   localparam logic [5:0] OP_ADDI = 6'h0C;
   localparam logic [5:0] OP_LUI  = 6'h0D;
   localparam logic [5:0] OP_MOV  = 6'h0E;
   localparam logic [5:0] OP_BEQ  = 6'h10;
   localparam logic [5:0] OP_BNE  = 6'h11;
   localparam logic [5:0] OP_JR   = 6'h12;
   localparam logic [5:0] OP_J    = 6'h13;

   logic [5:0]  opc;
   logic [4:0]  rd;
   logic [4:0]  sh;
   logic [31:0] se;
   logic [31:0] seq_pc;
   logic [31:0] br_pc;

   logic [31:0] res_d;
   logic [31:0] pc_d;
   logic [4:0]  rd_d;
   logic        wr;

   logic [31:0] res_q;
   logic [31:0] pc_q;
   logic [4:0]  rd_q;

   assign opc    = instr[31:26];
   assign rd     = instr[25:21];
   assign sh     = instr[10:6];
   assign se     = {{16{instr[15]}}, instr[15:0]};
   assign seq_pc = pc_in + 32'd8;
   assign br_pc  = seq_pc + {se[29:0], 2'b00};

   always_comb begin
      res_d = '0;
      pc_d  = seq_pc;
      wr    = 1'b0;
      unique case (opc)
         OP_ADD:  begin res_d = op_a + op_b; wr = 1'b1; end
         OP_SUB:  begin res_d = op_a - op_b; wr = 1'b1; end
         OP_AND:  begin res_d = op_a & op_b; wr = 1'b1; end
         OP_OR:   begin res_d = op_a | op_b; wr = 1'b1; end
         OP_XOR:  begin res_d = op_a ^ op_b; wr = 1'b1; end
         OP_NOR:  begin res_d = ~(op_a | op_b); wr = 1'b1; end
         OP_SLT: begin
            res_d = {31'd0, $signed(op_a) < $signed(op_b)};
            wr    = 1'b1;
         end
         OP_SLTU: begin
            res_d = {31'd0, op_a < op_b};
            wr    = 1'b1;
         end
         OP_SLL:  begin res_d = op_b << sh; wr = 1'b1; end
         OP_SRL:  begin res_d = op_b >> sh; wr = 1'b1; end
         OP_SRA: begin
            res_d = $unsigned($signed(op_b) >>> sh);
            wr    = 1'b1;
         end
         OP_ADDI: begin res_d = op_a + se; wr = 1'b1; end
         OP_LUI:  begin res_d = {instr[15:0], 16'h0}; wr = 1'b1; end
         OP_MOV:  begin res_d = op_a; wr = 1'b1; end
         // Control flow only steers the PC on lane 0; lane 1 treats it as NOP.
         OP_BEQ:  if (!lane && op_a == op_b) pc_d = br_pc;
         OP_BNE:  if (!lane && op_a != op_b) pc_d = br_pc;
         OP_JR:   if (!lane) pc_d = op_c;
         OP_J:    if (!lane) pc_d = {pc_in[31:28], instr[25:0], 2'b00};
         default: ;
      endcase
      if (!en) begin
         res_d = '0;
         wr    = 1'b0;
         pc_d  = pc_in;
      end
      rd_d = (wr && wen) ? rd : 5'd0;
   end

   always_ff @(posedge clk) begin
      if (rs) begin
         res_q <= '0;
         rd_q  <= '0;
         pc_q  <= '0;
      end else begin
         res_q <= res_d;
         rd_q  <= rd_d;
         pc_q  <= pc_d;
      end
   end

   assign result = res_q;
   assign rd_out = rd_q;
   assign pc_out = lane ? {32{1'bz}} : pc_q;

endmodule

// File: tb/tb_pap_alu.sv
// tb_pap_alu: directed and random checks of pap_alu against a reference model.
// A pulled-up pc net makes a floating lane 1 pc read as all ones.
module tb_pap_alu;

   logic        clk = 1'b0;
   logic        rs, lane, en, wen;
   logic [31:0] instr, pc_in, op_a, op_b, op_c;
   logic [4:0]  rd_out;
   logic [31:0] result;
   tri1  [31:0] pc_out;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pap_alu dut (
      .clk(clk), .rs(rs), .lane(lane), .instr(instr),
      .pc_in(pc_in), .op_a(op_a), .op_b(op_b), .op_c(op_c),
      .en(en), .wen(wen), .rd_out(rd_out), .pc_out(pc_out),
      .result(result)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int op, input int rd,
                                      input int imm);
      logic [31:0] w;
      w = 32'd0;
      w[31:26] = op[5:0];
      w[25:21] = rd[4:0];
      w[15:0]  = imm[15:0];
      return w;
   endfunction

   // Reference: what the lane should present after the edge.
   task automatic model(output logic [31:0] er, output logic [4:0] ed,
                        output logic [31:0] ep);
      int op;
      logic [31:0] sx, a, b, nx;
      logic writes;
      op = int'(instr[31:26]);
      a  = op_a;
      b  = op_b;
      sx = 32'(signed'(instr[15:0]));
      nx = pc_in + 32'd8;
      er = 0; writes = 0; ep = nx;
      if (op >= 1 && op <= 14) writes = 1;
      case (op)
         1:  er = a + b;
         2:  er = a + (~b) + 32'd1;
         3:  er = a & b;
         4:  er = a | b;
         5:  er = a ^ b;
         6:  er = ~(a | b);
         7:  er = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         8:  er = (a < b) ? 32'd1 : 32'd0;
         9:  er = b << instr[10:6];
         10: er = b >> instr[10:6];
         11: er = $signed(b) >>> instr[10:6];
         12: er = a + sx;
         13: er = 32'(instr[15:0]) * 32'h10000;
         14: er = a;
         16: if (!lane && a == b) ep = nx + sx * 4;
         17: if (!lane && a != b) ep = nx + sx * 4;
         18: if (!lane) ep = op_c;
         19: if (!lane) ep = {pc_in[31:28], instr[25:0], 2'b00};
         default: ;
      endcase
      if (!en) begin er = 0; writes = 0; ep = pc_in; end
      ed = (writes && wen) ? instr[25:21] : 5'd0;
      if (rs) begin er = 0; ed = 0; ep = 0; end
      if (lane) ep = 32'hFFFF_FFFF;
   endtask

   task automatic run(input string tag);
      logic [31:0] er, ep;
      logic [4:0] ed;
      model(er, ed, ep);
      @(posedge clk);
      #1;
      chk({tag, ".res"}, result, er);
      chk({tag, ".rd"}, 32'(rd_out), 32'(ed));
      chk({tag, ".pc"}, pc_out, ep);
   endtask

   task automatic set(input logic [31:0] i, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c);
      instr = i; pc_in = pc; op_a = a; op_b = b; op_c = c;
      en = 1; wen = 1; rs = 0;
   endtask

   initial begin
      lane = 0;
      set(mk(1, 3, 0), 32'h100, 32'd9, 32'd9, 0);
      rs = 1;
      run("rst0");
      chk("rst0.lit", result, 32'd0);
      run("rst1");
      rs = 0;
      run("live");
      chk("live.lit", result, 32'd18);

      set(mk(1, 3, 0), 32'h100, 32'hFFFF_FFFF, 32'd1, 0);
      run("add");
      chk("add.lit", {result[31:8], 3'd0, rd_out}, 32'd3);
      chk("add.pc", pc_out, 32'h108);
      set(mk(2, 1, 0), 32'h100, 0, 1, 0);
      run("sub");
      chk("sub.lit", result, 32'hFFFF_FFFF);
      set(mk(11, 2, 4 << 6), 32'h100, 0, 32'h8000_0000, 0);
      run("sra");
      chk("sra.lit", result, 32'hF800_0000);
      set(mk(7, 2, 0), 32'h100, 32'hFFFF_FFFF, 1, 0);
      run("slt");
      chk("slt.lit", result, 32'd1);
      set(mk(8, 2, 0), 32'h100, 32'hFFFF_FFFF, 1, 0);
      run("sltu");
      chk("sltu.lit", result, 32'd0);
      set(mk(12, 2, 16'hFFFE), 32'h100, 5, 0, 0);
      run("addi");
      chk("addi.lit", result, 32'd3);
      set(mk(13, 2, 16'h1234), 32'h100, 0, 0, 0);
      run("lui");
      chk("lui.lit", result, 32'h1234_0000);

      set(mk(16, 5, 16'hFFFF), 32'h40, 7, 7, 0);
      run("beq");
      chk("beq.lit", pc_out, 32'h44);
      chk("beq.rd", 32'(rd_out), 32'd0);
      set(mk(17, 0, 16'hFFFF), 32'h40, 7, 7, 0);
      run("bne");
      chk("bne.lit", pc_out, 32'h48);
      set(mk(19, 0, 16'h10), 32'h40, 0, 0, 0);
      run("j");
      chk("j.lit", pc_out, 32'h40);
      set(mk(18, 0, 0), 32'h40, 0, 0, 32'h200);
      run("jr");
      chk("jr.lit", pc_out, 32'h200);

      set(mk(1, 3, 0), 32'h80, 2, 3, 0);
      en = 0;
      run("en0");
      chk("en0.pc", pc_out, 32'h80);
      set(mk(1, 3, 0), 32'h80, 2, 2, 0);
      wen = 0;
      run("wen0");
      chk("wen0.lit", result, 32'd4);
      set(mk(1, 0, 0), 32'h80, 2, 2, 0);
      run("rd0");
      chk("rd0.lit", 32'(rd_out), 32'd0);
      set(mk(21, 7, 0), 32'h80, 2, 2, 0);
      run("undef");

      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            rs = 1;
            run("swap");
            lane = 1;
            set(mk(16, 4, 3), 32'h40, 7, 7, 9);
            rs = 1;
            run("l1rst");
            set(mk(16, 4, 3), 32'h40, 7, 7, 9);
            run("l1beq");
            chk("l1beq.lit", pc_out, 32'hFFFF_FFFF);
            set(mk(1, 4, 0), 32'h40, 2, 3, 0);
            run("l1add");
            chk("l1add.lit", result, 32'd5);
         end
         set({$urandom_range(0, 23) > 20 ? 6'($urandom)
                                         : 6'($urandom_range(0, 19)),
              26'($urandom)},
             $urandom, $urandom, $urandom, $urandom);
         if ($urandom_range(0, 3) == 0) op_b = op_a;
         en  = $urandom_range(0, 7) != 0;
         wen = $urandom_range(0, 7) != 0;
         rs  = $urandom_range(0, 31) == 0;
         run("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
